seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential 8-bit restoring divider: one quotient bit per clock, then a sign-fix cycle.
// Define DIV_SIGNED_EN to compile in two's-complement support; without it, is_signed is ignored.
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_signed,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero,
  output logic       arithmetic_overflow
);

  localparam int unsigned W    = 8;
  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [W:0]      rem_q, rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    remo_q, remo_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            signed_mode_c;
  logic            a_neg_c, b_neg_c;
  logic [W-1:0]    mag_a_c, mag_b_c;
  logic [W:0]      trial_c;
  logic            ge_c;

`ifdef DIV_SIGNED_EN
  assign signed_mode_c = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign signed_mode_c    = 1'b0;
`endif

  assign a_neg_c = signed_mode_c & dividend[W-1];
  assign b_neg_c = signed_mode_c & divisor[W-1];
  assign mag_a_c = a_neg_c ? W'(-dividend) : dividend;
  assign mag_b_c = b_neg_c ? W'(-divisor) : divisor;

  // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign trial_c = {rem_q[W-1:0], acc_q[W-1]};
  assign ge_c    = trial_c >= {1'b0, dsr_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    quo_d      = quo_q;
    remo_d     = remo_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
          end else begin
            state_d    = CALC;
            cnt_d      = '0;
            acc_d      = mag_a_c;
            dsr_d      = mag_b_c;
            rem_d      = '0;
            neg_quo_d  = a_neg_c ^ b_neg_c;
            neg_rem_d  = a_neg_c;
            ovf_pend_d = signed_mode_c && (dividend == 8'h80) && (divisor == 8'hFF);
          end
        end
      end
      CALC: begin
        rem_d = ge_c ? (trial_c - {1'b0, dsr_q}) : trial_c;
        acc_d = {acc_q[W-2:0], ge_c};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) state_d = FIX;
      end
      FIX: begin
        quo_d   = neg_quo_q ? W'(-acc_q) : acc_q;
        remo_d  = neg_rem_q ? W'(-rem_q[W-1:0]) : rem_q[W-1:0];
        dbz_d   = 1'b0;
        ovf_d   = ovf_pend_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quo_q      <= '0;
      remo_q     <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      quo_q      <= quo_d;
      remo_q     <= remo_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign quotient            = quo_q;
  assign remainder           = remo_q;
  assign div_by_zero         = dbz_q;
  assign arithmetic_overflow = ovf_q;

endmodule
